// File: rtl/bht_update_sched_if.sv
// Table write-port bus between the BHT update scheduler and the table.
// The scheduler drives the master side; the table array is the slave.
interface bht_update_sched_if #(
  parameter int IDX_W = 8
);
  logic [IDX_W-1:0] tbl_raddr;
  logic [1:0]       tbl_rdata;
  logic             tbl_we;
  logic [IDX_W-1:0] tbl_waddr;
  logic [1:0]       tbl_wdata;

  modport master (
    output tbl_raddr,
    input  tbl_rdata,
    output tbl_we,
    output tbl_waddr,
    output tbl_wdata
  );

  modport slave (
    input  tbl_raddr,
    output tbl_rdata,
    input  tbl_we,
    input  tbl_waddr,
    input  tbl_wdata
  );
endinterface

// File: rtl/bht_update_sched.sv
// BHT write-port scheduler: post-reset clear sweep, then queued 2-bit updates.
// Optional macro BHT_BYPASS_EN applies a resolution same-cycle when idle.
module bht_update_sched #(
  parameter int IDX_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [6:0]                  ex_opcode,
  input  logic                        ex_br,
  input  logic [IDX_W-1:0]            ex_idx,
  bht_update_sched_if.master          tbl,
  output logic                        init_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic [7:0]                  drop_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = IDX_W + 1;
  localparam logic [6:0] BR_OP = 7'b110_0011;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [7:0]       drop_q, drop_d;
  logic [EW-1:0]    mem_q [FIFO_DEPTH];
  logic [EW-1:0]    mem_d [FIFO_DEPTH];

  logic             res_v;
  logic             full;
  logic             pop;
  logic             byp;
  logic             push;
  logic             drop;
  logic [EW-1:0]    head;
  logic             we;
  logic [IDX_W-1:0] waddr;
  logic [IDX_W-1:0] raddr;
  logic [1:0]       wdata;

  function automatic logic [1:0] sat2(
    input logic [1:0] r,
    input logic       t
  );
    if (t) return (r == 2'b11) ? 2'b11 : r + 2'b01;
    else   return (r == 2'b00) ? 2'b00 : r - 2'b01;
  endfunction

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    drop_d  = drop_q;
    mem_d   = mem_q;
    we      = 1'b0;
    waddr   = '0;
    raddr   = '0;
    wdata   = 2'b00;
    pop     = 1'b0;
    byp     = 1'b0;
    res_v   = (ex_opcode == BR_OP);
    full    = (cnt_q == FULL_CNT);
    head    = mem_q[rd_q];

    unique case (state_q)
      S_INIT: begin
        // gated so the table sees no write while reset is held
        we    = rst_n;
        waddr = ptr_q;
        ptr_d = ptr_q + IDX_W'(1);
        if (ptr_q == '1) state_d = S_RUN;
      end
      S_RUN: begin
        if (cnt_q != '0) begin
          pop   = 1'b1;
          raddr = head[EW-1:1];
          we    = 1'b1;
          waddr = head[EW-1:1];
          wdata = sat2(tbl.tbl_rdata, head[0]);
        end
`ifdef BHT_BYPASS_EN
        else if (res_v) begin
          byp   = 1'b1;
          raddr = ex_idx;
          we    = 1'b1;
          waddr = ex_idx;
          wdata = sat2(tbl.tbl_rdata, ex_br);
        end
`endif
      end
      default: state_d = S_INIT;
    endcase

    push = res_v && !byp && (!full || pop);
    drop = res_v && !byp && full && !pop;

    if (push) begin
      mem_d[wr_q] = {ex_idx, ex_br};
      wr_d        = wr_q + AW'(1);
    end
    if (pop) rd_d = rd_q + AW'(1);

    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase

    if (drop && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      ptr_q   <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      drop_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
      mem_q   <= mem_d;
    end
  end

  assign tbl.tbl_raddr = raddr;
  assign tbl.tbl_we    = we;
  assign tbl.tbl_waddr = waddr;
  assign tbl.tbl_wdata = wdata;
  assign init_busy     = (state_q == S_INIT);
  assign fifo_count    = cnt_q;
  assign drop_cnt      = drop_q;

endmodule

// File: tb/tb_bht_update_sched.sv
// Scoreboard bench for bht_update_sched against a queue-based reference model.
// A behavioural table array answers reads and absorbs writes.
module tb_bht_update_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] ex_opcode;
  logic       ex_br;
  logic [7:0] ex_idx;
  logic       init_busy;
  logic [2:0] fifo_count;
  logic [7:0] drop_cnt;

  bht_update_sched_if #(.IDX_W(8)) tif ();

  bht_update_sched #(.IDX_W(8), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ex_opcode  (ex_opcode),
    .ex_br      (ex_br),
    .ex_idx     (ex_idx),
    .tbl        (tif),
    .init_busy  (init_busy),
    .fifo_count (fifo_count),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  // the table itself: garbage while reset is held, so the sweep must clear it
  logic [1:0] tbl_mem [256];
  assign tif.tbl_rdata = tbl_mem[tif.tbl_raddr];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) tbl_mem[i] <= 2'($urandom);
    end else if (tif.tbl_we) begin
      tbl_mem[tif.tbl_waddr] <= tif.tbl_wdata;
    end
  end

`ifdef BHT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [1:0] data;
    logic       busy;
    logic [2:0] cnt;
    logic [7:0] drop;
  } exp_t;

  exp_t       exq[$];
  int         ref_tbl [256];
  logic [8:0] mq[$];
  int         m_drop;
  int         sweep;
  int         vectors;
  int         miscompares;

  task automatic apply(input int idx, input bit br, inout exp_t e);
    if (br) ref_tbl[idx] = (ref_tbl[idx] >= 3) ? 3 : ref_tbl[idx] + 1;
    else    ref_tbl[idx] = (ref_tbl[idx] <= 0) ? 0 : ref_tbl[idx] - 1;
    e.we   = 1'b1;
    e.addr = 8'(idx);
    e.data = 2'(ref_tbl[idx]);
  endtask

  task automatic step(input bit rs, input bit v, input bit br,
                      input logic [7:0] idx);
    exp_t       e;
    logic [8:0] h;
    logic [6:0] op;
    bit         full;
    bit         pop;
    bit         byp;
    @(posedge clk);
    #1;
    op = 7'($urandom);
    if (op == 7'h63) op = 7'h67;
    rst_n     = !rs;
    ex_opcode = v ? 7'h63 : op;
    ex_br     = br;
    ex_idx    = idx;
    e.we = 1'b0; e.addr = '0; e.data = '0;
    e.busy = 1'b1; e.cnt = '0; e.drop = '0;
    if (rs) begin
      mq.delete();
      m_drop = 0;
      sweep  = 0;
    end else begin
      e.cnt  = 3'(mq.size());
      e.drop = 8'(m_drop);
      e.busy = (sweep < 256);
      full = (mq.size() == 4);
      pop  = 1'b0;
      byp  = 1'b0;
      if (sweep < 256) begin
        e.we = 1'b1; e.addr = 8'(sweep); e.data = 2'b00;
        ref_tbl[sweep] = 0;
        sweep++;
      end else if (mq.size() > 0) begin
        pop = 1'b1;
        h = mq.pop_front();
        apply(int'(h[8:1]), h[0], e);
      end else if (BYP && v) begin
        byp = 1'b1;
        apply(int'(idx), br, e);
      end
      if (v && !byp) begin
        if (!full || pop) mq.push_back({idx, br});
        else if (m_drop < 255) m_drop++;
      end
    end
    exq.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", n, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exq.size() > 0) begin
      e = exq.pop_front();
      chk("tbl_we", 32'(tif.tbl_we), 32'(e.we));
      if (e.we) begin
        chk("tbl_waddr", 32'(tif.tbl_waddr), 32'(e.addr));
        chk("tbl_wdata", 32'(tif.tbl_wdata), 32'(e.data));
      end
      chk("init_busy", 32'(init_busy), 32'(e.busy));
      chk("fifo_count", 32'(fifo_count), 32'(e.cnt));
      chk("drop_cnt", 32'(drop_cnt), 32'(e.drop));
      if (!rst_n) begin
        chk("rst_waddr", 32'(tif.tbl_waddr), 32'd0);
        chk("rst_wdata", 32'(tif.tbl_wdata), 32'd0);
        chk("rst_raddr", 32'(tif.tbl_raddr), 32'd0);
      end
    end
  end

  initial begin
    rst_n = 1'b0; ex_opcode = '0; ex_br = 1'b0; ex_idx = '0;
    vectors = 0; miscompares = 0; m_drop = 0; sweep = 0;
    for (int i = 0; i < 256; i++) ref_tbl[i] = 0;

    repeat (3) step(1'b1, 1'b0, 1'b0, 8'h00);
    // six resolutions during the sweep: four queue, two drop
    for (int c = 0; c < 260; c++) begin
      if (c >= 10 && c < 16)
        step(1'b0, 1'b1, 1'($urandom), 8'($urandom_range(128, 255)));
      else
        idle(1);
    end
    idle(4);

    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 8'h3C);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 8'h3C);
    idle(3);

    step(1'b0, 1'b1, 1'b1, 8'h10);
    step(1'b0, 1'b1, 1'b1, 8'h10);
    step(1'b0, 1'b1, 1'b0, 8'h10);
    idle(3);

    step(1'b0, 1'b1, 1'b1, 8'h01);
    idle(3);

    for (int i = 0; i < 400; i++)
      step(1'b0, 1'($urandom), 1'($urandom), 8'($urandom_range(0, 15)));
    idle(3);

    // reset again, then abort the sweep at pointer 100 with 3 entries queued
    repeat (2) step(1'b1, 1'b0, 1'b0, 8'h00);
    for (int c = 0; c < 100; c++) begin
      if (c >= 96 && c < 99) step(1'b0, 1'b1, 1'b1, 8'(8'hA0 + c));
      else idle(1);
    end
    repeat (2) step(1'b1, 1'b0, 1'b0, 8'h00);
    idle(262);
    for (int i = 0; i < 60; i++)
      step(1'b0, 1'($urandom), 1'($urandom), 8'($urandom_range(0, 7)));
    idle(3);

    @(posedge clk);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bht_update_sched.md
# bht_update_sched

Write-port scheduler for the 256-entry 2-bit branch history table. It sits between the EX stage and the table's single write port. It clears the table after reset with a sequential sweep, so the table needs no reset of its own. It queues EX-stage branch resolutions in a small FIFO and applies each one as a read-modify-write saturating counter update.

## Interface
Parameters:
- IDX_W, 8, table index width; the table has 2^IDX_W entries.
- FIFO_DEPTH, 4, resolution queue depth; must be a power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ex_opcode  in  7  EX-stage opcode; a resolution exists only when it equals 7'b110_0011.
- ex_br  in  1  EX-stage branch outcome; 1 = taken.
- ex_idx  in  IDX_W  table index of the EX-stage branch.
- tbl_raddr  out  IDX_W  combinational read address to the table.
- tbl_rdata  in  2  combinational read data from the table.
- tbl_we  out  1  table write enable.
- tbl_waddr  out  IDX_W  table write address.
- tbl_wdata  out  2  table write data.
- init_busy  out  1  high while the clear sweep runs; the fetch stage must force predict-not-taken while it is high.
- fifo_count  out  log2(FIFO_DEPTH)+1  number of queued resolutions.
- drop_cnt  out  8  saturating count of resolutions lost because the FIFO was full.

## Operation
- States: INIT and RUN.
- While rst_n is low, all outputs take these values:
  - init_busy=1, tbl_we=0, tbl_waddr=0, tbl_wdata=0, tbl_raddr=0;
  - fifo_count=0, drop_cnt=0, sweep pointer=0, state=INIT.
- INIT:
  - Each cycle: tbl_we=1, tbl_waddr=sweep pointer, tbl_wdata=2'b00; then the pointer increments.
  - After writing index 2^IDX_W-1, the next state is RUN and init_busy drops.
  - The FIFO is never popped in INIT.
- Push:
  - Condition: ex_opcode==7'b110_0011 and the FIFO is not full, or full but popping that same cycle.
  - Entry stored: {ex_idx, ex_br}.
  - If the FIFO is full and not popping, the resolution is dropped and drop_cnt increments, saturating at 255.
- RUN pop:
  - Whenever the FIFO is non-empty, pop the head.
  - tbl_raddr = head idx.
  - tbl_we=1, tbl_waddr = head idx.
  - tbl_wdata = taken ? (rdata==2'b11 ? 2'b11 : rdata+1) : (rdata==2'b00 ? 2'b00 : rdata-1), where rdata = tbl_rdata.
- The drain rate is one entry per cycle. In RUN the FIFO therefore holds at most one entry in steady state and never overflows; drops can occur only during INIT.
- Updates are applied strictly in resolution order.
- Consecutive updates to the same index are correct. The write of cycle t is visible on tbl_rdata at t+1, and no forwarding is required.
- When the FIFO is empty in RUN: tbl_we=0 and tbl_raddr=0.
- Simultaneous push and pop: both happen; fifo_count is unchanged.
- Reset asserted mid-sweep or mid-update immediately returns the block to the reset values above. Queued entries are discarded and not counted in drop_cnt.

## Timing
- INIT lasts exactly 2^IDX_W cycles after the first rising edge with rst_n high.
- init_busy is 0 starting from the cycle after the final sweep write.
- Resolution latency, bypass disabled:
  - Resolution presented in cycle t, FIFO empty, state RUN.
  - The entry is pushed at the edge ending t.
  - tbl_we=1 for it in cycle t+1.
  - The new counter value is readable at t+2.
- Queued entries are written one per cycle in FIFO order.
- fifo_count reflects the registered occupancy.

## Configuration
- BHT_BYPASS_EN:
  - Defined: in RUN with the FIFO empty, a valid resolution is applied in the same cycle. tbl_raddr=ex_idx and tbl_we=1 in cycle t; no push occurs and fifo_count stays 0. If the FIFO is non-empty, the normal push path is used, which preserves ordering.
  - Not defined: every resolution goes through the FIFO, giving a fixed one-cycle extra latency.
  - INIT behaviour is identical in both builds.

## Test plan
- Reset then idle:
  - tbl_we=1 with waddr 0..255 for 256 consecutive cycles, wdata=0.
  - init_busy falls after the write to 255.
  - fifo_count=0, drop_cnt=0.
- Saturation in RUN, idx 8'h3C:
  - Five taken resolutions: wdata sequence 1,2,3,3,3.
  - Then five not-taken: 2,1,0,0,0.
  - Check against a table model.
- Back-to-back same index:
  - Taken, taken, not-taken to idx 8'h10 on consecutive cycles, starting from 0.
  - Required writes: 1, 2, 1, one per cycle.
- Overflow during INIT, FIFO_DEPTH=4:
  - Six resolutions during the sweep: fifo_count=4 and drop_cnt=2.
  - After INIT, four updates are written in order on consecutive cycles.
- Bypass check, RUN with FIFO empty, taken to idx 8'h01:
  - BHT_BYPASS_EN defined: tbl_we=1 in the same cycle, fifo_count stays 0.
  - Not defined: tbl_we=1 one cycle later.
- Reset mid-sweep at pointer 100 with 3 entries queued:
  - After rst_n rises, the sweep restarts at 0.
  - fifo_count=0, drop_cnt=0, and no queued update is ever written.
